serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised bit-serial add/subtract unit for the lab2 ALU datapath. It is the sequential successor to the 1-bit full-adder cell. A single DIGIT-wide ripple stage is reused over N/DIGIT cycles to produce an N-bit sum, carry-out and signed overflow. Operands are accepted through a ready/start handshake, and the result is announced with a one-cycle valid pulse.

## Interface
- N, default 32: operand and result width in bits.
- DIGIT, default 1: bits processed per cycle. Must divide N.
- clk  in  1  system clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation. Sampled only while ready=1.
- sub  in  1  0 = A+B, 1 = A−B. Sampled with start.
- A  in  N  first operand. Sampled with start.
- B  in  N  second operand. Sampled with start.
- ready  out  1  unit idle and able to accept start.
- valid  out  1  one-cycle pulse: S, Co and V hold a new result.
- S  out  N  result. Held until the next accepted start completes.
- Co  out  1  carry out of the MSB. For subtract: 1 = no borrow, i.e. A ≥ B unsigned.
- V  out  1  two's-complement overflow.

## Operation
- The state machine has three states: IDLE, RUN and DONE. ready = (state==IDLE). valid = (state==DONE).
- IDLE, start=1:
  - Latch A into opA and B^{N{sub}} into opB.
  - Set the carry register to sub and the digit counter to 0.
  - Go to RUN.
- IDLE, start=0: stay in IDLE. S, Co and V hold their values.
- RUN, each cycle:
  - Add opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - Shift the DIGIT sum bits into the top of the result shift register, LSB-first overall.
  - Shift opA and opB right by DIGIT. Update carry. Increment the counter.
- RUN exit: when the counter reaches N/DIGIT−1, the last digit is processed that cycle and the state goes to DONE.
  - Co is loaded with the final carry.
  - V is loaded with (carry into bit N−1) XOR (carry out of bit N−1).
- DONE: lasts exactly one cycle, then returns to IDLE. start is ignored because ready=0.
- start during RUN or DONE is ignored. Operands and sub are not re-sampled.
- Arithmetic is modulo 2^N. S = (A + B) mod 2^N, or (A + ~B + 1) mod 2^N.
- Reset, asynchronous and at any time including mid-RUN:
  - State goes to IDLE; counter, carry, opA, opB, S, Co and V go to 0.
  - After reset: ready=1, valid=0.
  - An in-flight operation is discarded and no valid is emitted.

## Timing
- Let L = N/DIGIT. start is accepted on rising edge k.
  - Edges k+1 … k+L process the digits.
  - valid is high during the cycle after edge k+L.
  - ready returns at edge k+L+1.
- Latency from the accepting edge to valid is L cycles. Back-to-back throughput is one operation per L+2 cycles.
- S, Co, V, ready and valid are all registered. No combinational path runs from inputs to outputs.
- During RUN, S shows partial shift contents. It is only meaningful while valid=1 and afterwards until the next accepted start.
- Reset values: ready=1, valid=0, S=0, Co=0, V=0.

## Configuration
- Macro: SERIAL_ADDER_SUB_EN.
- Defined: subtract mode is supported exactly as described above.
- Undefined:
  - The sub port remains but is ignored.
  - opB is always latched uninverted and the initial carry is always 0, so every operation is A+B.
  - Co and V keep their addition meaning.

## Test plan
- Reset: assert rst mid-cycle with no clock edge → outputs go immediately to ready=1, valid=0, S=0, Co=0, V=0.
- N=8, DIGIT=1: A=8'h7F, B=8'h01, sub=0 → S=8'h80, Co=0, V=1. valid pulses for exactly one cycle, 8 cycles after the accepting edge. ready returns one cycle later.
- N=8: A=8'hFF, B=8'h01, sub=0 → S=8'h00, Co=1, V=0.
- N=8: A=8'h05, B=8'h07, sub=1:
  - With SERIAL_ADDER_SUB_EN → S=8'hFE, Co=0, V=0.
  - Without it → S=8'h0C, Co=0, V=0.
- Busy and reset behaviour:
  - Accept A=8'h10, B=8'h20.
  - At RUN cycle 3, pulse start with A=8'hFF, B=8'hFF → ignored; the result is S=8'h30.
  - Repeat, but assert rst at RUN cycle 4 → no valid pulse; ready=1 at once.
- N=32, DIGIT=4: A=32'h8000_0000, B=32'h8000_0000 → S=0, Co=1, V=1, valid 8 cycles after the accepting edge.

Source files
------------

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder
// ----------------------------------------------------------------------------
// Bit-serial add/subtract unit for the lab2 ALU datapath. This is the
// sequential successor to the 1-bit full-adder cell. One DIGIT-wide ripple
// stage is reused over N/DIGIT cycles. Together those cycles produce an N-bit
// sum, the carry out of the MSB and the two's-complement overflow flag.
//
// Parameters
//   N      operand / result width in bits (default 32)
//   DIGIT  bits processed per cycle (default 1); must divide N
//
// Ports
//   clk    in   1  system clock, all state updates on the rising edge
//   rst    in   1  asynchronous, active-high reset
//   start  in   1  request a new operation, sampled only while ready=1
//   sub    in   1  0 = A+B, 1 = A-B, sampled with start
//   A      in   N  first operand, sampled with start
//   B      in   N  second operand, sampled with start
//   ready  out  1  unit idle and able to accept start
//   valid  out  1  one-cycle pulse: S, Co and V hold a new result
//   S      out  N  result, held until the next accepted start completes
//   Co     out  1  carry out of the MSB (subtract: 1 = no borrow, A >= B)
//   V      out  1  two's-complement overflow
//
// Timing
//   Start is accepted on edge k. Edges k+1 .. k+N/DIGIT each process one
//   digit, LSB-first. valid is high for the cycle after edge k+N/DIGIT, and
//   ready returns one edge later. S shows partial shift contents while the
//   operation runs.
//
// Configuration
//   SERIAL_ADDER_SUB_EN  When defined, subtract mode is honoured. When it is
//                        undefined, the sub port is ignored and every
//                        operation is A+B.
// ============================================================================
module serial_adder #(
  parameter int N     = 32,
  parameter int DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         ready,
  output logic         valid,
  output logic [N-1:0] S,
  output logic         Co,
  output logic         V
);

  // Number of digit steps per operation, and the width of the digit counter.
  localparam int L  = N / DIGIT;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(L - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic          carry;
  logic [CW-1:0] cnt;

  logic          sub_eff;
  logic          accept;
  logic          last_digit;
  logic [DIGIT:0] digit_sum;
  logic          msb_carry_in;
  logic [N-1:0]  s_shift;

  // --------------------------------------------------------------------------
  // Subtract enable. Without the feature, sub is tied off through a constant
  // AND. That keeps the port connected while the logic reduces to plain
  // addition.
  // --------------------------------------------------------------------------
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = sub & 1'b0;
`endif

  assign accept     = (state == IDLE) && start;
  assign last_digit = (state == RUN) && (cnt == LAST_DIGIT);

  // --------------------------------------------------------------------------
  // Digit ripple stage. The result is DIGIT sum bits plus the carry out.
  // --------------------------------------------------------------------------
  assign digit_sum = {1'b0, op_a[DIGIT-1:0]}
                   + {1'b0, op_b[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry};

  // Recover the carry into the top bit of this digit from its sum bit:
  // s = a ^ b ^ cin, so cin = a ^ b ^ s. On the last digit this is the carry
  // into bit N-1, which the overflow flag needs.
  assign msb_carry_in = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ digit_sum[DIGIT-1];

  // New sum bits enter at the top of S. After L steps the first digit has
  // reached the bottom, so the result ends up LSB-aligned.
  generate
    if (N > DIGIT) begin : g_shift
      assign s_shift = {digit_sum[DIGIT-1:0], S[N-1:DIGIT]};
    end else begin : g_single
      assign s_shift = digit_sum[DIGIT-1:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM state register. ready and valid are registered decodes of the next
  // state, so no input reaches an output combinationally.
  // --------------------------------------------------------------------------
  // NOTE: state-holding processes use non-blocking (<=) assignments only.
  // Every flop then samples pre-edge values, whatever the process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      ready <= (state_next == IDLE);
      valid <= (state_next == DONE);
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  // NOTE: the default at the top covers every path through the case. Without
  // it, a missed branch would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)      state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand shifters, carry, digit counter, result and flags.
  // --------------------------------------------------------------------------
  // NOTE: operand registers are reset along with the visible outputs. An
  // aborted operation then leaves nothing behind, and every flop is in a
  // known state right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Co    <= 1'b0;
      V     <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1. The +1 enters as the initial carry.
      op_a  <= A;
      op_b  <= B ^ {N{sub_eff}};
      carry <= sub_eff;
      cnt   <= '0;
    end else if (state == RUN) begin
      S     <= s_shift;
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      carry <= digit_sum[DIGIT];
      cnt   <= cnt + CW'(1);
      if (last_digit) begin
        Co <= digit_sum[DIGIT];
        V  <= msb_carry_in ^ digit_sum[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder
// ----------------------------------------------------------------------------
// Two instances share one clock and one reset:
//   u_dut8   N=8,  DIGIT=1
//   u_dut32  N=32, DIGIT=4
// Expected results come from an arithmetic model. The model uses unsigned
// modulo sums for S and Co, and signed range checks for V. Both builds, with
// and without SERIAL_ADDER_SUB_EN, are covered through the same macro.
// ============================================================================
module tb_serial_adder;

  localparam int LAT = 8;  // N/DIGIT for both instances

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start8, sub8, ready8, valid8, co8, v8;
  logic [7:0]  a8, b8, s8;
  logic        start32, sub32, ready32, valid32, co32, v32;
  logic [31:0] a32, b32, s32;

  serial_adder #(.N(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .A(a8), .B(b8),
    .ready(ready8), .valid(valid8), .S(s8), .Co(co8), .V(v8)
  );

  serial_adder #(.N(32), .DIGIT(4)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .sub(sub32), .A(a32), .B(b32),
    .ready(ready32), .valid(valid32), .S(s32), .Co(co32), .V(v32)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model. S and Co come from unsigned modulo-2^n arithmetic.
  // V is set when the signed result falls outside the n-bit range.
  function automatic void model(input int n, input logic [31:0] a,
                                input logic [31:0] b, input logic s,
                                output logic [31:0] s_exp,
                                output logic co_exp, output logic v_exp);
    longint unsigned m, ua, ub, full;
    longint half, sa, sb, res;
    logic es;
`ifdef SERIAL_ADDER_SUB_EN
    es = s;
`else
    es = s & 1'b0;
`endif
    m    = (64'd1 << n) - 64'd1;
    ua   = {32'd0, a} & m;
    ub   = {32'd0, b} & m;
    half = longint'(64'd1 << (n - 1));
    sa   = (ua >= 64'(half)) ? longint'(ua) - 2 * half : longint'(ua);
    sb   = (ub >= 64'(half)) ? longint'(ub) - 2 * half : longint'(ub);
    if (es) begin
      s_exp  = 32'((ua - ub) & m);
      co_exp = (ua >= ub);
      res    = sa - sb;
    end else begin
      full   = ua + ub;
      s_exp  = 32'(full & m);
      co_exp = ((full >> n) & 64'd1) != 64'd0;
      res    = sa + sb;
    end
    v_exp = (res < -half) || (res >= half);
  endfunction

  task automatic drive(input bit wide, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic s);
    if (wide) begin
      start32 = st; a32 = a; b32 = b; sub32 = s;
    end else begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0]; sub8 = s;
    end
  endtask

  function automatic logic get_ready(input bit wide);
    return wide ? ready32 : ready8;
  endfunction
  function automatic logic get_valid(input bit wide);
    return wide ? valid32 : valid8;
  endfunction
  function automatic logic [31:0] get_s(input bit wide);
    return wide ? s32 : {24'd0, s8};
  endfunction
  function automatic logic get_co(input bit wide);
    return wide ? co32 : co8;
  endfunction
  function automatic logic get_v(input bit wide);
    return wide ? v32 : v8;
  endfunction

  // Runs one operation on the selected instance.
  //   poke_cyc  RUN cycle at which a spurious start with all-ones operands
  //             is pulsed (-1 = none).
  //   rst_cyc   RUN cycle at which reset is asserted mid-cycle (-1 = none).
  //             The in-flight result must then be discarded.
  task automatic run_op(input bit wide, input logic [31:0] a,
                        input logic [31:0] b, input logic s,
                        input int poke_cyc, input int rst_cyc,
                        input string tag);
    logic [31:0] s_exp;
    logic co_exp, v_exp, seen;
    int cycles;
    model(wide ? 32 : 8, a, b, s, s_exp, co_exp, v_exp);

    @(negedge clk);
    check({tag, "_ready_idle"}, get_ready(wide), 1'b1);
    drive(wide, 1'b1, a, b, s);
    @(posedge clk);
    #1;
    // Operands change right after acceptance and must not be re-sampled.
    drive(wide, 1'b0, $urandom, $urandom, ~s);

    cycles = 0;
    while (1) begin
      @(negedge clk);
      if (get_valid(wide)) break;
      cycles++;
      if (cycles == poke_cyc)
        drive(wide, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ~s);
      else if (cycles == poke_cyc + 1)
        drive(wide, 1'b0, 32'h0, 32'h0, 1'b0);
      if (cycles == rst_cyc) begin
        #2 rst = 1'b1;
        #1;
        check({tag, "_rst_ready"}, get_ready(wide), 1'b1);
        check({tag, "_rst_valid"}, get_valid(wide), 1'b0);
        check({tag, "_rst_s"}, get_s(wide), 32'h0);
        seen = 1'b0;
        repeat (12) begin
          @(negedge clk);
          seen |= get_valid(wide);
        end
        check({tag, "_rst_no_valid"}, seen, 1'b0);
        rst = 1'b0;
        return;
      end
      if (cycles > 40) begin
        check({tag, "_timeout"}, cycles, LAT);
        return;
      end
    end

    check({tag, "_latency"}, cycles, LAT);
    check({tag, "_ready_busy"}, get_ready(wide), 1'b0);
    check({tag, "_s"}, get_s(wide), s_exp);
    check({tag, "_co"}, get_co(wide), co_exp);
    check({tag, "_v"}, get_v(wide), v_exp);
    @(negedge clk);
    check({tag, "_valid_pulse"}, get_valid(wide), 1'b0);
    check({tag, "_ready_back"}, get_ready(wide), 1'b1);
    @(negedge clk);
    check({tag, "_s_hold"}, get_s(wide), s_exp);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    #7;
    check("rst_ready8", ready8, 1'b1);
    check("rst_valid8", valid8, 1'b0);
    check("rst_s8", s8, 8'h00);
    check("rst_co8", co8, 1'b0);
    check("rst_v8", v8, 1'b0);
    check("rst_ready32", ready32, 1'b1);
    check("rst_s32", s32, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(1'b0, 32'h7F, 32'h01, 1'b0, -1, -1, "add_7f_01");
    check("add_7f_01_const_s", s8, 8'h80);
    check("add_7f_01_const_v", v8, 1'b1);
    run_op(1'b0, 32'hFF, 32'h01, 1'b0, -1, -1, "add_ff_01");
    check("add_ff_01_const_co", co8, 1'b1);
    run_op(1'b0, 32'h05, 32'h07, 1'b1, -1, -1, "sub_05_07");
`ifdef SERIAL_ADDER_SUB_EN
    check("sub_05_07_const_s", s8, 8'hFE);
`else
    check("sub_05_07_const_s", s8, 8'h0C);
`endif

    // start while busy is ignored
    run_op(1'b0, 32'h10, 32'h20, 1'b0, 3, -1, "busy");
    check("busy_const_s", s8, 8'h30);
    // reset mid-RUN discards the operation
    run_op(1'b0, 32'h10, 32'h20, 1'b0, -1, 4, "rst_mid");

    // Asynchronous reset between clock edges clears held results at once
    run_op(1'b0, 32'h7F, 32'h01, 1'b0, -1, -1, "pre_async");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_ready", ready8, 1'b1);
    check("async_valid", valid8, 1'b0);
    check("async_s", s8, 8'h00);
    check("async_co", co8, 1'b0);
    check("async_v", v8, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Wide instance, multi-bit digits
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, -1, -1, "w_add_min");
    check("w_add_min_const_co", co32, 1'b1);
    check("w_add_min_const_v", v32, 1'b1);
    run_op(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, -1, "w_sub_edge");

    // Randomised operations on both instances
    for (int i = 0; i < 30; i++) begin
      run_op(1'b0, $urandom, $urandom, 1'($urandom), -1, -1, "rnd8");
      run_op(1'b1, $urandom, $urandom, 1'($urandom), -1, -1, "rnd32");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
